// File: rtl/instruction_execute.sv
// EX stage: single-cycle ALU plus a 32-step shift-add multiplier. While the multiplier runs,
// busy stalls upstream and exOut carries a bubble.
module instruction_execute #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IN_W   = 148,
  parameter int unsigned OUT_W  = 72
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  bufferIn,
  output logic             busy,
  output logic [OUT_W-1:0] exOut
);

  typedef enum logic {StIdle, StMul} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] op1_q, op2_q, acc_q, rd3_q;
  logic [4:0]        cnt_q;
  logic [3:0]        rc_q;
  logic              mem_write_q, mem_to_reg_q, branch_flag_q;

  // ID/EX bundle fields
  logic              imm_src, branch_flag, mem_write, mem_to_reg;
  logic [3:0]        alu_control, rc;
  logic [DATA_W-1:0] rd1, rd2, rd3, extend_imm, op1, op2, result, acc_nxt;
  logic              unused_regs;

  assign imm_src     = bufferIn[147];
  assign branch_flag = bufferIn[146];
  assign mem_write   = bufferIn[145];
  assign mem_to_reg  = bufferIn[144];
  assign alu_control = bufferIn[143:140];
  assign rd1         = bufferIn[135:104];
  assign rd2         = bufferIn[99:68];
  assign rc          = bufferIn[67:64];
  assign rd3         = bufferIn[63:32];
  assign extend_imm  = bufferIn[31:0];
  // Source register numbers are only needed by forwarding logic upstream.
  assign unused_regs = ^{bufferIn[139:136], bufferIn[103:100]};

  assign op1 = rd1;
  assign op2 = imm_src ? extend_imm : rd2;

  always_comb begin
    result = '0;
    case (alu_control)
      4'b0000: result = op1 + op2;
      4'b0001: result = op1 - op2;
      4'b0010: result = op1 & op2;
      4'b0011: result = op1 | op2;
      4'b0100: result = op1 ^ op2;
      4'b0101: result = op1 << op2[4:0];
      4'b0110: result = op1 >> op2[4:0];
      4'b0111: result = $unsigned($signed(op1) >>> op2[4:0]);
      4'b1001: result = op2;
      default: result = '0;
    endcase
  end

  // One shift-add step: add op1 << cnt when multiplier bit cnt is set.
  assign acc_nxt = acc_q + (op2_q[cnt_q] ? (op1_q << cnt_q) : '0);

  assign busy = (state_q == StMul);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      exOut         <= '0;
      op1_q         <= '0;
      op2_q         <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      rd3_q         <= '0;
      rc_q          <= '0;
      mem_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      branch_flag_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en) begin
            if (alu_control == 4'b1000) begin
              op1_q         <= op1;
              op2_q         <= op2;
              rd3_q         <= rd3;
              rc_q          <= rc;
              mem_write_q   <= mem_write;
              mem_to_reg_q  <= mem_to_reg;
              branch_flag_q <= branch_flag;
              acc_q         <= '0;
              cnt_q         <= '0;
              exOut         <= '0;
              state_q       <= StMul;
            end else begin
              exOut <= {1'b1, branch_flag & (result == '0), mem_write, mem_to_reg, rc,
                        result, rd3};
            end
          end
        end
        StMul: begin
          acc_q <= acc_nxt;
          if (cnt_q == 5'd31) begin
            exOut   <= {1'b1, branch_flag_q & (acc_nxt == '0), mem_write_q, mem_to_reg_q, rc_q,
                        acc_nxt, rd3_q};
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_execute.sv
// Scoreboard bench for instruction_execute: ALU ops, branches, multi-cycle MUL, hold, reset.
module tb_instruction_execute;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [147:0] bufferIn;
  logic         busy;
  logic [71:0]  exOut;

  int n_cmp = 0;
  int n_bad = 0;
  logic [71:0] sb_q[$];

  instruction_execute dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .bufferIn (bufferIn),
    .busy     (busy),
    .exOut    (exOut)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [147:0] mk(logic imm, logic bf, logic mw, logic mtr, logic [3:0] ctl,
                                      logic [31:0] rd1, logic [31:0] rd2, logic [3:0] rc,
                                      logic [31:0] rd3, logic [31:0] ext);
    return {imm, bf, mw, mtr, ctl, 4'h1, rd1, 4'h2, rd2, rc, rd3, ext};
  endfunction

  function automatic logic [71:0] model(logic [147:0] b);
    logic [31:0] a, o, r;
    a = b[135:104];
    o = b[147] ? b[31:0] : b[99:68];
    case (b[143:140])
      4'd0: r = a + o;
      4'd1: r = a - o;
      4'd2: r = a & o;
      4'd3: r = a | o;
      4'd4: r = a ^ o;
      4'd5: r = a << o[4:0];
      4'd6: r = a >> o[4:0];
      4'd7: r = $unsigned($signed(a) >>> o[4:0]);
      4'd8: r = a * o;
      4'd9: r = o;
      default: r = 32'd0;
    endcase
    return {1'b1, b[146] & (r == 32'd0), b[145], b[144], b[67:64], r, b[63:32]};
  endfunction

  function automatic logic [147:0] rnd_bundle();
    return mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
              $urandom, $urandom, 4'($urandom), $urandom, $urandom);
  endfunction

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_pop(input string tag);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got output expected empty scoreboard", tag);
    end else begin
      check_eq(tag, exOut, sb_q.pop_front());
    end
  endtask

  task automatic run_op(input string tag, input logic [147:0] b);
    bufferIn = b;
    en       = 1'b1;
    sb_q.push_back(model(b));
    @(posedge clk); #1;
    en = 1'b0;
    check_pop(tag);
    check_eq({tag, "_busy"}, 72'(busy), 72'd0);
  endtask

  // abort_at > 0 asserts reset at that busy cycle instead of waiting for the product.
  task automatic run_mul(input string tag, input logic [147:0] b, input int abort_at);
    int n;
    bufferIn = b;
    en       = 1'b1;
    sb_q.push_back(model(b));
    @(posedge clk); #1;
    n = 0;
    while (busy && n < 40) begin
      n++;
      check_eq({tag, "_bubble"}, exOut, 72'd0);
      if (n == abort_at) begin
        rst = 1'b1;
        en  = 1'b0;
        #1;
        check_eq({tag, "_rst_busy"}, 72'(busy), 72'd0);
        check_eq({tag, "_rst_exout"}, exOut, 72'd0);
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      en       = 1'($urandom);
      bufferIn = rnd_bundle();
      @(posedge clk); #1;
    end
    en = 1'b0;
    check_eq({tag, "_busy_cycles"}, 72'(n), 72'd32);
    check_pop(tag);
    check_eq({tag, "_busy_after"}, 72'(busy), 72'd0);
  endtask

  initial begin
    logic [147:0] b;
    logic [71:0]  held;
    rst      = 1'b1;
    en       = 1'b0;
    bufferIn = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_exout", exOut, 72'd0);
    check_eq("reset_busy", 72'(busy), 72'd0);
    rst      = 1'b0;
    bufferIn = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd1, 32'd1, 4'd3, 32'd0, 32'd0);
    @(posedge clk); #1;
    check_eq("no_capture_en0", exOut, 72'd0);

    run_op("add", mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd5, 32'd7, 4'd3, 32'hAA, 32'd0));
    check_eq("add_result", 72'(exOut[63:32]), 72'd12);
    check_eq("add_valid_bt", 72'(exOut[71:70]), 72'd2);

    run_op("sub_imm", mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 32'd3, 32'd99, 4'd5, 32'h55,
                         32'hFFFFFFFF));
    check_eq("sub_imm_result", 72'(exOut[63:32]), 72'd4);

    run_op("beq_taken", mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 32'd9, 32'd9, 4'd0, 32'd0, 32'd0));
    check_eq("beq_taken_bt", 72'(exOut[70]), 72'd1);
    run_op("beq_not", mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 32'd9, 32'd8, 4'd0, 32'd0, 32'd0));
    check_eq("beq_not_bt", 72'(exOut[70]), 72'd0);

    for (int c = 2; c < 16; c++) begin
      if (c != 8) begin
        run_op($sformatf("alu_%0d", c),
               mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'(c), $urandom,
                  $urandom, 4'($urandom), $urandom, $urandom));
      end
    end
    run_op("sra_neg", mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 32'h80000010, 32'd0, 4'd1, 32'd0, 32'd4));
    check_eq("sra_neg_result", 72'(exOut[63:32]), 72'hF8000001);

    run_mul("mul", mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd8, 32'h00001234, 32'h00000100, 4'd7,
                      32'hCAFE, 32'd0), 0);
    check_eq("mul_result", 72'(exOut[63:32]), 72'h00123400);
    // Back-to-back: the next MUL is captured at the edge right after the product.
    run_mul("mul_b2b", mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd8, $urandom, 32'd0, 4'd2, $urandom,
                          $urandom), 0);
    run_mul("mul_rand", mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd8, $urandom, $urandom, 4'd9, $urandom,
                           32'd0), 0);

    run_mul("mul_abort", mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd8, 32'h1234, 32'h100, 4'd1, 32'd0,
                            32'd0), 10);
    run_op("add_after_rst", mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'd20, 32'd22, 4'd6, 32'h77,
                               32'd0));
    check_eq("add_after_rst_result", 72'(exOut[63:32]), 72'd42);

    b = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'd100, 32'd23, 4'd4, 32'h1111, 32'd0);
    held = model(b);
    run_op("hold_add", b);
    for (int i = 0; i < 5; i++) begin
      bufferIn = rnd_bundle();
      @(posedge clk); #1;
      check_eq($sformatf("hold_%0d", i), exOut, held);
    end

    check_eq("sb_empty", 72'(sb_q.size()), 72'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
